// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer time-sharing one full_adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_r;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry_r),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit i sits at position i.
    always_comb begin
        sum_next = sum >> 1;
        sum_next[WIDTH-1] = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_r <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_r <= fa_carry;
                    sum     <= sum_next;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_carry;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the result is simply the (WIDTH+1)-bit sum of the operands and carry-in.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {8'b0, c};
    endfunction

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic [7:0] esum, input logic ecout, input string tag);
        int ncyc;
        int nbusy;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        ncyc = 0;
        nbusy = 0;
        while (!done8 && ncyc < 40) begin
            if (busy8) nbusy++;
            ncyc++;
            @(negedge clk);
        end
        check({tag, " done_seen"}, 32'(done8), 32'd1);
        check({tag, " busy_cycles"}, nbusy, 8);
        check({tag, " latency"}, ncyc, 8);
        check({tag, " sum"}, 32'(sum8), 32'(esum));
        check({tag, " cout"}, 32'(cout8), 32'(ecout));
        @(negedge clk);
        check({tag, " done_pulse_end"}, 32'(done8), 32'd0);
        check({tag, " sum_held"}, 32'(sum8), 32'(esum));
    endtask

    initial begin
        logic [8:0] exp9;
        logic [7:0] ra, rb;
        logic       rc;
        int         pulses;
        logic [7:0] cap_sum;
        logic       cap_cout;
        logic [7:0] opa[64];
        logic [7:0] opb[64];
        logic       opc[64];
        int         bad_done;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset busy", 32'(busy8), 0);
        check("reset done", 32'(done8), 0);
        check("reset sum", 32'(sum8), 0);
        check("reset cout", 32'(cout8), 0);
        check("reset w1 busy", 32'(busy1), 0);
        check("reset w1 done", 32'(done1), 0);

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].esum, vecs[i].ecout, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp9 = model8(ra, rb, rc);
            do_op(ra, rb, rc, exp9[7:0], exp9[8], $sformatf("rand%0d", i));
        end

        // Start re-pulsed mid-run must be ignored.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0; cap_sum = 8'hEE; cap_cout = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (done8) begin
                pulses++;
                cap_sum = sum8;
                cap_cout = cout8;
            end
            @(negedge clk);
        end
        check("ignore pulses", pulses, 1);
        check("ignore sum", 32'(cap_sum), 32'h03);
        check("ignore cout", 32'(cap_cout), 0);

        // Reset asserted on the 4th RUN cycle aborts the operation.
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset busy", 32'(busy8), 0);
        check("midreset done", 32'(done8), 0);
        check("midreset sum", 32'(sum8), 0);
        check("midreset cout", 32'(cout8), 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) pulses++;
            @(negedge clk);
        end
        check("midreset stays idle", pulses, 0);
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "after_reset");

        // start held high: accepts at edges 0,9,18,...; done visible at negedge 9k.
        bad_done = 0;
        for (int n = 0; n < 46; n++) begin
            @(negedge clk);
            if (n > 0) begin
                if (done8 !== (n % 9 == 0)) bad_done++;
                if (n % 9 == 0) begin
                    exp9 = model8(opa[n-9], opb[n-9], opc[n-9]);
                    check($sformatf("b2b sum k%0d", n / 9), 32'(sum8), 32'(exp9[7:0]));
                    check($sformatf("b2b cout k%0d", n / 9), 32'(cout8), 32'(exp9[8]));
                end
            end
            opa[n] = 8'($urandom); opb[n] = 8'($urandom); opc[n] = 1'($urandom);
            a8 = opa[n]; b8 = opb[n]; cin8 = opc[n]; start8 = 1'b1;
        end
        start8 = 1'b0;
        check("b2b done pattern", bad_done, 0);
        repeat (12) @(negedge clk);

        // WIDTH=1 full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] e;
            v = 3'(i);
            e = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check($sformatf("w1 busy run %0d", i), 32'(busy1), 1);
            check($sformatf("w1 early done %0d", i), 32'(done1), 0);
            @(negedge clk);
            check($sformatf("w1 done %0d", i), 32'(done1), 1);
            check($sformatf("w1 busy done %0d", i), 32'(busy1), 0);
            check($sformatf("w1 result %0d", i), 32'({cout1, sum1}), 32'(e));
            @(negedge clk);
            check($sformatf("w1 done end %0d", i), 32'(done1), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
